// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: read-owner encoding,
// fetch access width code and default sizing parameters.
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

    localparam int RAM_SIZE       = 16;
    localparam int DATA_WIDTH     = 64;
    localparam int STARVE_MAX_DEF = 4;

    localparam logic [2:0] WID_WORD = 3'b010;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } mem_owner_e;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating fetch-starvation counter.
// Ports: clk_i, rst_ni, clr_i (clear), inc_i (count up), at_max_o (== MAX).
`timescale 1ns/1ps
module arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    assign at_max_o = (cnt == CW'(MAX));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (inc_i && !at_max_o) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single RAM port arbiter: data-priority grant with fetch starvation guard,
// read-owner tracking for response routing, and fetch stall generation.
// Ports: fetch side (if_*), data side (d_*), RAM side (mem_*), stall_if_o.
`timescale 1ns/1ps
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = RAM_SIZE,
    parameter int DATA_W     = DATA_WIDTH,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    output logic              stall_if_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [2:0]        d_wid_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [2:0]        mem_wid_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    logic       at_max;
    mem_owner_e owner;

    // Data wins ties unless fetch has been refused STARVE_MAX times in a row.
    assign if_gnt_o   = if_req_i & (~d_req_i | at_max);
    assign d_gnt_o    = d_req_i & ~(if_req_i & at_max);
    assign stall_if_o = if_req_i & ~if_gnt_o;

    assign mem_en_o    = rst_ni & (if_gnt_o | d_gnt_o);
    assign mem_we_o    = rst_ni & d_gnt_o & d_we_i;
    assign mem_addr_o  = if_gnt_o ? if_addr_i :
                         d_gnt_o  ? d_addr_i  : '0;
    assign mem_wdata_o = d_gnt_o ? d_wdata_i : '0;
    assign mem_wid_o   = if_gnt_o ? WID_WORD :
                         d_gnt_o  ? d_wid_i  : 3'b000;

    assign if_rvalid_o = (owner == OWN_IF);
    assign d_rvalid_o  = (owner == OWN_D);
    assign if_rdata_o  = mem_rdata_i[31:0];
    assign d_rdata_o   = mem_rdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner <= OWN_NONE;
        end else if (if_gnt_o) begin
            owner <= OWN_IF;
        end else if (d_gnt_o && !d_we_i) begin
            owner <= OWN_D;
        end else begin
            owner <= OWN_NONE;
        end
    end

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (if_gnt_o | ~if_req_i),
        .inc_i    (stall_if_o),
        .at_max_o (at_max)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small synchronous RAM model.
// Directed cycles check grants combinationally; a monitor checks responses.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid, stall_if;
    logic [31:0]   if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [2:0]    d_wid = 3'b0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_wid;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] ram [0:1023];

    typedef struct {
        bit            is_if;
        logic [DW-1:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .stall_if_o  (stall_if),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_wid_i     (d_wid),
        .d_gnt_o     (d_gnt),
        .d_rvalid_o  (d_rvalid),
        .d_rdata_o   (d_rdata),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wid_o   (mem_wid),
        .mem_rdata_i (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr[9:0]] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    task automatic check(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Response monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        if (if_rvalid || d_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid got if=%0b d=%0b exp=none",
                         if_rvalid, d_rvalid);
            end else begin
                resp_t r;
                r = exp_q.pop_front();
                check("rvalid_if", {63'b0, if_rvalid}, {63'b0, r.is_if});
                check("rvalid_d", {63'b0, d_rvalid}, {63'b0, !r.is_if});
                if (r.is_if)
                    check("if_rdata", {32'b0, if_rdata}, {32'b0, r.data[31:0]});
                else
                    check("d_rdata", d_rdata, r.data);
            end
        end
    end

    task automatic cyc(input logic ir, input logic [AW-1:0] ia,
                       input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                       input logic [2:0] dwid);
        @(negedge clk);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dwd;
        d_wid   = dwid;
        #1;
    endtask

    task automatic chk_gnt(input string name, input logic eif,
                           input logic ed, input logic estall,
                           input logic emen);
        check({name, "_if_gnt"}, {63'b0, if_gnt}, {63'b0, eif});
        check({name, "_d_gnt"}, {63'b0, d_gnt}, {63'b0, ed});
        check({name, "_stall"}, {63'b0, stall_if}, {63'b0, estall});
        check({name, "_mem_en"}, {63'b0, mem_en}, {63'b0, emen});
    endtask

    task automatic push(input bit is_if, input logic [DW-1:0] data);
        resp_t r;
        r.is_if = is_if;
        r.data  = data;
        exp_q.push_back(r);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        ram[10'h100] = 64'h0000_0000_0050_0093;
        ram[10'h200] = 64'h1122_3344_5566_7788;
        ram[10'h208] = 64'hCAFE_F00D_1234_5678;

        // Reset with both requests up: grants follow inputs, RAM idle.
        cyc(1, 16'h0100, 1, 0, 16'h0200, '0, 3'b011);
        @(negedge clk);
        #1;
        check("rst_mem_en", {63'b0, mem_en}, 64'd0);
        check("rst_if_rvalid", {63'b0, if_rvalid}, 64'd0);
        check("rst_d_rvalid", {63'b0, d_rvalid}, 64'd0);
        check("rst_d_gnt", {63'b0, d_gnt}, 64'd1);

        // Release: first cycle grants data.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_gnt("rel", 0, 1, 1, 1);
        check("rel_addr", {48'b0, mem_addr}, 64'h200);
        push(0, 64'h1122_3344_5566_7788);

        // Fetch only.
        cyc(1, 16'h0100, 0, 0, '0, '0, 3'b0);
        chk_gnt("fetch", 1, 0, 0, 1);
        check("fetch_addr", {48'b0, mem_addr}, 64'h100);
        check("fetch_we", {63'b0, mem_we}, 64'd0);
        check("fetch_wid", {61'b0, mem_wid}, 64'd2);
        push(1, 64'h0050_0093);

        // Fetch and load together: data wins.
        cyc(1, 16'h0100, 1, 0, 16'h0208, '0, 3'b011);
        chk_gnt("both", 0, 1, 1, 1);
        check("both_addr", {48'b0, mem_addr}, 64'h208);
        push(0, 64'hCAFE_F00D_1234_5678);

        // Idle: counter clears, RAM port quiet.
        cyc(0, 16'h0100, 0, 0, 16'h0208, 64'h55, 3'b0);
        chk_gnt("idle", 0, 0, 0, 0);
        check("idle_addr", {48'b0, mem_addr}, 64'h0);
        check("idle_wdata", mem_wdata, 64'h0);

        // Starvation with loads: 4 data grants then one fetch, repeating.
        for (int k = 0; k < 10; k++) begin
            cyc(1, 16'h0100, 1, 0, 16'h0200, '0, 3'b011);
            if (k % 5 == 4) begin
                chk_gnt($sformatf("starve%0d", k), 1, 0, 0, 1);
                push(1, 64'h0050_0093);
            end else begin
                chk_gnt($sformatf("starve%0d", k), 0, 1, 1, 1);
                push(0, 64'h1122_3344_5566_7788);
            end
        end

        // Starvation with stores: fetch wins at the limit, store stalls.
        for (int k = 0; k < 5; k++) begin
            cyc(1, 16'h0100, 1, 1, 16'h0300, 64'hDEAD_BEEF, 3'b010);
            if (k == 4) begin
                chk_gnt("st_starve4", 1, 0, 0, 1);
                check("st_starve4_we", {63'b0, mem_we}, 64'd0);
                push(1, 64'h0050_0093);
            end else begin
                chk_gnt($sformatf("st_starve%0d", k), 0, 1, 1, 1);
                check("st_we", {63'b0, mem_we}, 64'd1);
            end
        end
        cyc(0, '0, 0, 0, '0, '0, 3'b0);

        // Store then fetch; store gives no rvalid.
        cyc(0, 16'h0100, 1, 1, 16'h0300, 64'hDEAD_BEEF, 3'b011);
        chk_gnt("store", 0, 1, 0, 1);
        check("store_we", {63'b0, mem_we}, 64'd1);
        check("store_wdata", mem_wdata, 64'hDEAD_BEEF);
        check("store_wid", {61'b0, mem_wid}, 64'd3);
        cyc(1, 16'h0100, 0, 0, '0, '0, 3'b0);
        chk_gnt("after_store", 1, 0, 0, 1);
        push(1, 64'h0050_0093);
        cyc(0, '0, 1, 0, 16'h0300, '0, 3'b011);
        chk_gnt("readback", 0, 1, 0, 1);
        push(0, 64'hDEAD_BEEF);
        cyc(0, '0, 0, 0, '0, '0, 3'b0);

        // Reset pulsed right after a granted load: response dropped.
        cyc(0, '0, 1, 0, 16'h0200, '0, 3'b011);
        chk_gnt("rst_load", 0, 1, 0, 1);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        d_req  = 1'b0;
        #1;
        check("rst_mid_d_rvalid", {63'b0, d_rvalid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_d_rvalid", {63'b0, d_rvalid}, 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
